// File: rtl/load_queue.sv
// In-order load queue: buffers RS loads, issues them one at a time to the memory
// controller, extends the returned data and writes the result back to its IQ slot.
module load_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int IQ_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                update_stat,
  input  logic                clear_flag_in,
  output logic                rs_full_out,
  input  logic                rs_load_enable_in,
  input  logic [2:0]          rs_func3_in,
  input  logic [ADDR_W-1:0]   rs_addr_in,
  input  logic [IQ_IDX_W-1:0] rs_pos_in_iq_in,
  output logic                mc_fetch_enable_out,
  output logic [ADDR_W-1:0]   mc_addr_out,
  output logic [1:0]          mc_len_out,
  input  logic                mc_result_enable_in,
  input  logic [DATA_W-1:0]   mc_data_in,
  output logic                iq_write_enable_out,
  output logic [IQ_IDX_W-1:0] iq_write_idx_out,
  output logic [DATA_W-1:0]   iq_write_result_out,
  output logic                iq_write_ready_out,
  output logic                iq_write_need_cdb_out
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_enq;
  logic                w_issue;
  logic                w_done;
  logic [1:0]          w_len;

  logic [ADDR_W-1:0]   r_addr_q [DEPTH];
  logic [1:0]          r_len_q  [DEPTH];
  logic                r_uns_q  [DEPTH];
  logic [IQ_IDX_W-1:0] r_idx_q  [DEPTH];

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] data,
                                                    input logic [1:0] len,
                                                    input logic uns);
    logic [DATA_W-1:0] res;
    case (len)
      2'd0:    res = {{(DATA_W-8){~uns & data[7]}}, data[7:0]};
      2'd1:    res = {{(DATA_W-16){~uns & data[15]}}, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  // funct3[1] set means LW (or reserved) -> full word
  assign w_len = rs_func3_in[1] ? 2'd3 : rs_func3_in[1:0];
  assign w_enq = update_stat && rs_load_enable_in && !rs_full_out && !clear_flag_in;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!clear_flag_in && r_count != '0) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mc_result_enable_in) begin
          w_done      = !clear_flag_in;
          w_state_nxt = S_IDLE;
        end else if (clear_flag_in) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // the orphaned result is swallowed even if another clear coincides with it
        if (mc_result_enable_in) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_count_nxt = r_count;
    if (clear_flag_in) begin
      w_count_nxt = '0;
    end else begin
      case ({w_enq, w_done})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && w_enq) begin
      r_addr_q[r_tail] <= rs_addr_in;
      r_len_q[r_tail]  <= w_len;
      r_uns_q[r_tail]  <= rs_func3_in[2];
      r_idx_q[r_tail]  <= rs_pos_in_iq_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state               <= S_IDLE;
      r_head                <= '0;
      r_tail                <= '0;
      r_count               <= '0;
      rs_full_out           <= 1'b0;
      mc_fetch_enable_out   <= 1'b0;
      mc_addr_out           <= '0;
      mc_len_out            <= '0;
      iq_write_enable_out   <= 1'b0;
      iq_write_idx_out      <= '0;
      iq_write_result_out   <= '0;
      iq_write_ready_out    <= 1'b0;
      iq_write_need_cdb_out <= 1'b0;
    end else if (!rdy) begin
      mc_fetch_enable_out   <= 1'b0;
      iq_write_enable_out   <= 1'b0;
      iq_write_ready_out    <= 1'b0;
      iq_write_need_cdb_out <= 1'b0;
    end else begin
      r_state               <= w_state_nxt;
      r_count               <= w_count_nxt;
      rs_full_out           <= (w_count_nxt == FULL_CNT);
      mc_fetch_enable_out   <= w_issue;
      iq_write_enable_out   <= w_done;
      iq_write_ready_out    <= w_done;
      iq_write_need_cdb_out <= w_done;
      if (w_issue) begin
        mc_addr_out <= r_addr_q[r_head];
        mc_len_out  <= r_len_q[r_head];
      end
      // head entry stays put while its access is in flight
      if (w_done) begin
        iq_write_idx_out    <= r_idx_q[r_head];
        iq_write_result_out <= extend_load(mc_data_in, r_len_q[r_head], r_uns_q[r_head]);
      end
      if (clear_flag_in) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_enq)  r_tail <= r_tail + 1'b1;
        if (w_done) r_head <= r_head + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_load_queue.sv
// Directed bench for load_queue: hand-computed vectors checked with immediate assertions.
module tb_load_queue;
  logic        clk;
  logic        rst;
  logic        rdy;
  logic        update_stat;
  logic        clear_flag_in;
  logic        rs_full_out;
  logic        rs_load_enable_in;
  logic [2:0]  rs_func3_in;
  logic [31:0] rs_addr_in;
  logic [3:0]  rs_pos_in_iq_in;
  logic        mc_fetch_enable_out;
  logic [31:0] mc_addr_out;
  logic [1:0]  mc_len_out;
  logic        mc_result_enable_in;
  logic [31:0] mc_data_in;
  logic        iq_write_enable_out;
  logic [3:0]  iq_write_idx_out;
  logic [31:0] iq_write_result_out;
  logic        iq_write_ready_out;
  logic        iq_write_need_cdb_out;

  int total = 0;
  int bad   = 0;

  load_queue dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .update_stat          (update_stat),
    .clear_flag_in        (clear_flag_in),
    .rs_full_out          (rs_full_out),
    .rs_load_enable_in    (rs_load_enable_in),
    .rs_func3_in          (rs_func3_in),
    .rs_addr_in           (rs_addr_in),
    .rs_pos_in_iq_in      (rs_pos_in_iq_in),
    .mc_fetch_enable_out  (mc_fetch_enable_out),
    .mc_addr_out          (mc_addr_out),
    .mc_len_out           (mc_len_out),
    .mc_result_enable_in  (mc_result_enable_in),
    .mc_data_in           (mc_data_in),
    .iq_write_enable_out  (iq_write_enable_out),
    .iq_write_idx_out     (iq_write_idx_out),
    .iq_write_result_out  (iq_write_result_out),
    .iq_write_ready_out   (iq_write_ready_out),
    .iq_write_need_cdb_out(iq_write_need_cdb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [2:0] f3, input logic [3:0] idx);
    rs_load_enable_in = 1'b1;
    rs_addr_in        = a;
    rs_func3_in       = f3;
    rs_pos_in_iq_in   = idx;
  endtask

  // Waits (bounded) for the issue pulse, answers two cycles later, checks the write-back.
  task automatic serve(input string tag, input logic [31:0] a, input logic [1:0] len,
                       input logic [31:0] d, input logic [3:0] idx, input logic [31:0] res);
    int n;
    n = 0;
    while (mc_fetch_enable_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".fetch"}, 32'(mc_fetch_enable_out), 32'd1);
    chk({tag, ".addr"}, mc_addr_out, a);
    chk({tag, ".len"}, 32'(mc_len_out), 32'(len));
    tick();
    chk({tag, ".fetch_pulse"}, 32'(mc_fetch_enable_out), 32'd0);
    mc_result_enable_in = 1'b1;
    mc_data_in          = d;
    tick();
    mc_result_enable_in = 1'b0;
    chk({tag, ".we"}, 32'(iq_write_enable_out), 32'd1);
    chk({tag, ".idx"}, 32'(iq_write_idx_out), 32'(idx));
    chk({tag, ".result"}, iq_write_result_out, res);
    chk({tag, ".ready"}, 32'(iq_write_ready_out), 32'd1);
    chk({tag, ".need_cdb"}, 32'(iq_write_need_cdb_out), 32'd1);
    tick();
    chk({tag, ".we_pulse"}, 32'(iq_write_enable_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; update_stat = 1'b1; clear_flag_in = 1'b0;
    rs_load_enable_in = 1'b0; rs_func3_in = 3'd0; rs_addr_in = 32'd0; rs_pos_in_iq_in = 4'd0;
    mc_result_enable_in = 1'b0; mc_data_in = 32'd0;
    tick();
    tick();
    chk("rst.full", 32'(rs_full_out), 32'd0);
    chk("rst.fetch", 32'(mc_fetch_enable_out), 32'd0);
    chk("rst.addr", mc_addr_out, 32'd0);
    chk("rst.len", 32'(mc_len_out), 32'd0);
    chk("rst.we", 32'(iq_write_enable_out), 32'd0);
    chk("rst.idx", 32'(iq_write_idx_out), 32'd0);
    chk("rst.result", iq_write_result_out, 32'd0);
    chk("rst.ready", 32'(iq_write_ready_out), 32'd0);
    chk("rst.need_cdb", 32'(iq_write_need_cdb_out), 32'd0);
    rst = 1'b0;

    // single LB, negative byte
    enq(32'h100, 3'd0, 4'd5);
    tick();
    rs_load_enable_in = 1'b0;
    chk("lb.no_same_cycle_issue", 32'(mc_fetch_enable_out), 32'd0);
    serve("lb", 32'h100, 2'd0, 32'h0000_00F0, 4'd5, 32'hFFFF_FFF0);

    // LHU / LH / LW back to back
    enq(32'h200, 3'd5, 4'd1);
    tick();
    enq(32'h204, 3'd1, 4'd2);
    tick();
    chk("lhu.fetch", 32'(mc_fetch_enable_out), 32'd1);
    chk("lhu.addr", mc_addr_out, 32'h200);
    chk("lhu.len", 32'(mc_len_out), 32'd1);
    enq(32'h208, 3'd2, 4'd3);
    tick();
    rs_load_enable_in = 1'b0;
    chk("lhu.fetch_pulse", 32'(mc_fetch_enable_out), 32'd0);
    mc_result_enable_in = 1'b1;
    mc_data_in = 32'h0000_8001;
    tick();
    mc_result_enable_in = 1'b0;
    chk("lhu.we", 32'(iq_write_enable_out), 32'd1);
    chk("lhu.idx", 32'(iq_write_idx_out), 32'd1);
    chk("lhu.result", iq_write_result_out, 32'h0000_8001);
    serve("lh", 32'h204, 2'd1, 32'h0000_8001, 4'd2, 32'hFFFF_8001);
    serve("lw", 32'h208, 2'd3, 32'h0000_8001, 4'd3, 32'h0000_8001);

    // fill to DEPTH with the MC stalled, then wrap the tail
    enq(32'h300, 3'd2, 4'd8);
    tick();
    chk("fill.full_after1", 32'(rs_full_out), 32'd0);
    enq(32'h304, 3'd2, 4'd9);
    tick();
    chk("fill.fetch", 32'(mc_fetch_enable_out), 32'd1);
    chk("fill.addr", mc_addr_out, 32'h300);
    enq(32'h308, 3'd2, 4'd10);
    tick();
    chk("fill.full_after3", 32'(rs_full_out), 32'd0);
    enq(32'h30C, 3'd2, 4'd11);
    tick();
    chk("fill.full_after4", 32'(rs_full_out), 32'd1);
    enq(32'h3F0, 3'd2, 4'd15);
    tick();
    rs_load_enable_in = 1'b0;
    chk("fill.full_after5th", 32'(rs_full_out), 32'd1);
    mc_result_enable_in = 1'b1;
    mc_data_in = 32'hA000_0008;
    tick();
    mc_result_enable_in = 1'b0;
    chk("fill.we", 32'(iq_write_enable_out), 32'd1);
    chk("fill.idx_head_intact", 32'(iq_write_idx_out), 32'd8);
    chk("fill.result", iq_write_result_out, 32'hA000_0008);
    chk("fill.full_dropped", 32'(rs_full_out), 32'd0);
    enq(32'h340, 3'd2, 4'd12);
    tick();
    rs_load_enable_in = 1'b0;
    chk("wrap.full_again", 32'(rs_full_out), 32'd1);
    serve("wrap9", 32'h304, 2'd3, 32'hA000_0009, 4'd9, 32'hA000_0009);
    serve("wrap10", 32'h308, 2'd3, 32'hA000_000A, 4'd10, 32'hA000_000A);
    serve("wrap11", 32'h30C, 2'd3, 32'hA000_000B, 4'd11, 32'hA000_000B);
    serve("wrap12", 32'h340, 2'd3, 32'hA000_000C, 4'd12, 32'hA000_000C);
    chk("wrap.full_empty", 32'(rs_full_out), 32'd0);
    tick();
    chk("wrap.no_5th_issue", 32'(mc_fetch_enable_out), 32'd0);

    // clear in WAIT with three queued loads; enqueue during DRAIN
    enq(32'h400, 3'd2, 4'd1);
    tick();
    enq(32'h404, 3'd2, 4'd2);
    tick();
    chk("clr.fetch", 32'(mc_fetch_enable_out), 32'd1);
    chk("clr.addr", mc_addr_out, 32'h400);
    enq(32'h408, 3'd2, 4'd3);
    tick();
    rs_load_enable_in = 1'b0;
    clear_flag_in = 1'b1;
    tick();
    clear_flag_in = 1'b0;
    chk("clr.full", 32'(rs_full_out), 32'd0);
    chk("clr.we", 32'(iq_write_enable_out), 32'd0);
    enq(32'h500, 3'd4, 4'd6);
    tick();
    rs_load_enable_in = 1'b0;
    chk("drain.no_issue1", 32'(mc_fetch_enable_out), 32'd0);
    tick();
    chk("drain.no_issue2", 32'(mc_fetch_enable_out), 32'd0);
    mc_result_enable_in = 1'b1;
    mc_data_in = 32'h1111_1111;
    tick();
    mc_result_enable_in = 1'b0;
    chk("drain.discard_we", 32'(iq_write_enable_out), 32'd0);
    chk("drain.no_issue3", 32'(mc_fetch_enable_out), 32'd0);
    serve("lbu", 32'h500, 2'd0, 32'h0000_0080, 4'd6, 32'h0000_0080);
    chk("clr.no_stale1", 32'(mc_fetch_enable_out), 32'd0);
    tick();
    chk("clr.no_stale2", 32'(mc_fetch_enable_out), 32'd0);

    // clear together with MC result and RS enqueue
    enq(32'h600, 3'd2, 4'd7);
    tick();
    rs_load_enable_in = 1'b0;
    tick();
    chk("clr2.fetch", 32'(mc_fetch_enable_out), 32'd1);
    chk("clr2.addr", mc_addr_out, 32'h600);
    clear_flag_in = 1'b1;
    mc_result_enable_in = 1'b1;
    mc_data_in = 32'h2222_2222;
    enq(32'h700, 3'd2, 4'd9);
    tick();
    clear_flag_in = 1'b0;
    mc_result_enable_in = 1'b0;
    rs_load_enable_in = 1'b0;
    chk("clr2.we", 32'(iq_write_enable_out), 32'd0);
    chk("clr2.full", 32'(rs_full_out), 32'd0);
    tick();
    chk("clr2.no_enq1", 32'(mc_fetch_enable_out), 32'd0);
    tick();
    chk("clr2.no_enq2", 32'(mc_fetch_enable_out), 32'd0);
    enq(32'h800, 3'd0, 4'd4);
    tick();
    rs_load_enable_in = 1'b0;
    serve("clr2.after", 32'h800, 2'd0, 32'h0000_007F, 4'd4, 32'h0000_007F);

    // rdy low for three cycles mid-WAIT
    enq(32'h900, 3'd1, 4'd13);
    tick();
    rs_load_enable_in = 1'b0;
    tick();
    chk("rdy.fetch", 32'(mc_fetch_enable_out), 32'd1);
    chk("rdy.addr", mc_addr_out, 32'h900);
    chk("rdy.len", 32'(mc_len_out), 32'd1);
    rdy = 1'b0;
    enq(32'hA00, 3'd2, 4'd14);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy.frozen_fetch", 32'(mc_fetch_enable_out), 32'd0);
      chk("rdy.frozen_we", 32'(iq_write_enable_out), 32'd0);
    end
    rdy = 1'b1;
    rs_load_enable_in = 1'b0;
    mc_result_enable_in = 1'b1;
    mc_data_in = 32'hABCD_8000;
    tick();
    mc_result_enable_in = 1'b0;
    chk("rdy.we", 32'(iq_write_enable_out), 32'd1);
    chk("rdy.idx", 32'(iq_write_idx_out), 32'd13);
    chk("rdy.result", iq_write_result_out, 32'hFFFF_8000);
    tick();
    chk("rdy.we_pulse", 32'(iq_write_enable_out), 32'd0);
    tick();
    chk("rdy.no_enq_while_low", 32'(mc_fetch_enable_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
